sw_debounce: RTL and testbench



---
 rtl/sw_debounce_pkg.sv | 17 +
 rtl/db_cell.sv | 105 ++++++++++
 rtl/sw_debounce.sv | 35 +++
 tb/tb_sw_debounce.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and helpers for the slide-switch debouncer.
// Holds the per-cell state encoding and the counter-width rule.
package sw_debounce_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } db_state_t;

    localparam int DEF_DB_CYCLES = 1_000_000;

    // The counter must be able to hold DB_CYCLES-1 at minimum.
    function automatic int db_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/db_cell.sv
// Single-bit debouncer: two-flop synchroniser, stability counter and level register.
// Optional edge pulses are built only when SW_DEBOUNCE_EDGE_EN is defined.
module db_cell
    import sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = db_cnt_w(DEF_DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_reg;
    logic             s2_reg;
    logic             db_reg;
    logic             db_next;
    db_state_t        state_reg;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            db_reg    <= 1'b0;
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            s1_reg    <= pin;
            s2_reg    <= s1_reg;
            db_reg    <= db_next;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        db_next    = db_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s2_reg != db_reg) begin
                    state_next = COUNT;
                    cnt_next   = CNT_ONE;
                end
            end
            COUNT: begin
                if (s2_reg == db_reg) begin
                    // Input fell back before the window expired: bounce rejected.
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    db_next    = s2_reg;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign db = db_reg;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_reg;
    logic fall_reg;

    // Pulses land on the same edge as the level update, so they line up with the new db.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= accept & s2_reg;
            fall_reg <= accept & ~s2_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign rise          = 1'b0;
    assign fall          = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch input conditioner: one db_cell per switch bit, wiring only.
// Define SW_DEBOUNCE_EDGE_EN to build the sw_rise/sw_fall pulse outputs.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = db_cnt_w(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_pin,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            db_cell #(
                .DB_CYCLES (DB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .pin  (sw_pin[gi]),
                .db   (sw_db[gi]),
                .rise (sw_rise[gi]),
                .fall (sw_fall[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with DB_CYCLES=4: directed scenarios plus random bounce.
// Reference model: a bit flips once the last DB_CYCLES synchronised samples all disagree with it.
module tb_sw_debounce;

    localparam int WIDTH = 8;
    localparam int DB    = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_pin;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    int checks;
    int errors;

    logic [WIDTH-1:0] m_s1;
    logic [WIDTH-1:0] m_s2;
    logic [WIDTH-1:0] m_db;
    logic [WIDTH-1:0] m_rise;
    logic [WIDTH-1:0] m_fall;
    logic [WIDTH-1:0] hist[$];

    sw_debounce #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_pin  (sw_pin),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] pulse_exp(input logic [WIDTH-1:0] p);
`ifdef SW_DEBOUNCE_EDGE_EN
        return p;
`else
        return '0;
`endif
    endfunction

    task automatic model_clear();
        m_s1   = '0;
        m_s2   = '0;
        m_db   = '0;
        m_rise = '0;
        m_fall = '0;
        hist.delete();
    endtask

    task automatic check_model();
        check("sw_db", sw_db, m_db);
        check("sw_rise", sw_rise, pulse_exp(m_rise));
        check("sw_fall", sw_fall, pulse_exp(m_fall));
    endtask

    // Entered and left at a falling edge: check, drive, take one rising edge, update the model.
    task automatic cycle(input logic [WIDTH-1:0] pin);
        logic [WIDTH-1:0] nd;
        logic             all_diff;
        check_model();
        sw_pin = pin;
        @(posedge clk);
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        nd = m_db;
        if (hist.size() == DB) begin
            for (int b = 0; b < WIDTH; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (hist[k][b] == m_db[b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~m_db[b];
            end
        end
        m_rise = nd & ~m_db;
        m_fall = ~nd & m_db;
        if (nd != m_db)
            $display("t=%0t accept sw_db %h -> %h (pin %h)", $time, m_db, nd, pin);
        m_db = nd;
        m_s2 = m_s1;
        m_s1 = pin;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] pin, input int len);
        rst    = 1'b1;
        sw_pin = pin;
        model_clear();
        #1;
        check("rst_db", sw_db, '0);
        check("rst_rise", sw_rise, '0);
        check("rst_fall", sw_fall, '0);
        repeat (len) @(negedge clk);
        check("rst_hold_db", sw_db, '0);
        rst = 1'b0;
        $display("t=%0t reset released, pin %h", $time, pin);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        sw_pin = '0;
        model_clear();
        @(negedge clk);

        // Power-on style: all switches high through reset.
        do_reset(8'hFF, 3);
        repeat (5) cycle(8'hFF);
        check("s1_before", sw_db, 8'h00);
        cycle(8'hFF);
        check("s1_db", sw_db, 8'hFF);
        check("s1_rise", sw_rise, pulse_exp(8'hFF));
        cycle(8'hFF);
        check("s1_rise_once", sw_rise, 8'h00);
        repeat (4) cycle(8'hFF);

        // Bounce on bit 0.
        do_reset(8'h00, 2);
        repeat (8) cycle(8'h00);
        foreach (hist[k]) ;
        for (int i = 0; i < 9; i++) cycle((i % 4) < 2 ? 8'h01 : 8'h00);
        repeat (4) cycle(8'h01);
        check("bounce_before", sw_db, 8'h00);
        cycle(8'h01);
        check("bounce_db", sw_db, 8'h01);
        repeat (6) cycle(8'h01);

        // Glitches on bit 3: 3 cycles rejected, 4 cycles accepted.
        do_reset(8'h00, 2);
        repeat (6) cycle(8'h00);
        repeat (3) cycle(8'h08);
        repeat (8) cycle(8'h00);
        check("glitch3_db", sw_db, 8'h00);
        repeat (4) cycle(8'h08);
        repeat (2) cycle(8'h00);
        check("glitch4_db", sw_db, 8'h08);
        repeat (6) cycle(8'h00);

        // Parallel changes, bit 2 one cycle behind bits 1 and 6.
        do_reset(8'h00, 2);
        repeat (6) cycle(8'h00);
        cycle(8'h42);
        repeat (10) cycle(8'h46);

        // Reset in the middle of a count.
        do_reset(8'h00, 2);
        repeat (6) cycle(8'h00);
        repeat (2) cycle(8'h20);
        do_reset(8'h20, 1);
        repeat (5) cycle(8'h20);
        check("midrst_before", sw_db, 8'h00);
        cycle(8'h20);
        check("midrst_db", sw_db, 8'h20);
        repeat (3) cycle(8'h20);

        // Random bouncing with occasional resets.
        do_reset(8'h00, 2);
        begin
            logic [WIDTH-1:0] pin;
            pin = '0;
            for (int n = 0; n < 3000; n++) begin
                for (int b = 0; b < WIDTH; b++)
                    if ($urandom_range(0, 5) == 0) pin[b] = ~pin[b];
                if ($urandom_range(0, 999) == 0)
                    do_reset(pin, $urandom_range(1, 3));
                else
                    cycle(pin);
            end
        end
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
